// File: rtl/pipe_exmem.sv
// pipe_exmem: EX->MEM pipeline register with multi-cycle accumulator feedback.
//
// Each cycle takes exactly one action, in priority order:
//   reset > flush > bubble > advance > hold
//   bubble  (stall_en[3] & !stall_en[4]) : payload <- 0, acc/cnt <- ex_acc_in/ex_cnt_in
//   advance (!stall_en[3])               : payload <- ex_*, acc/cnt <- 0
//   hold    (stall_en[3] &  stall_en[4]) : payload kept, acc/cnt <- ex_acc_in/ex_cnt_in
// Every output is a flop output, so there is no combinational path from input to output.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   flush               kill the EX->MEM transfer and abort any multi-cycle op
//   stall_en[5:0]       stall vector; only bit 3 (EX) and bit 4 (MEM) are used
//   ex_*                EX-stage payload, HI/LO request and multi-cycle partial result
//   mem_*               registered MEM-stage payload
//   acc_out, cnt_out    registered partial result {hi,lo} and step count fed back to EX
//   perf_*              bubble/hold event counters (only with PIPE_EXMEM_PERF_EN)
//
// Build option: define PIPE_EXMEM_PERF_EN to add perf_clr, perf_bubble_cnt and perf_hold_cnt.

module pipe_exmem #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [5:0]           stall_en,
  input  logic                 ex_valid,
  input  logic [RADDR_W-1:0]   ex_wr_addr,
  input  logic                 ex_wr_en,
  input  logic [DATA_W-1:0]    ex_wr_data,
  input  logic                 ex_hilo_en,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic [2*DATA_W-1:0]  ex_acc_in,
  input  logic [CNT_W-1:0]     ex_cnt_in,
  output logic                 mem_valid,
  output logic [RADDR_W-1:0]   mem_wr_addr,
  output logic                 mem_wr_en,
  output logic [DATA_W-1:0]    mem_wr_data,
  output logic                 mem_hilo_en,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic [2*DATA_W-1:0]  acc_out,
  output logic [CNT_W-1:0]     cnt_out
`ifdef PIPE_EXMEM_PERF_EN
  ,
  input  logic                 perf_clr,
  output logic [PERF_W-1:0]    perf_bubble_cnt,
  output logic [PERF_W-1:0]    perf_hold_cnt
`endif
);

  logic                do_bubble;
  logic                do_advance;
  logic                do_hold;

  logic                valid_q, valid_d;
  logic [RADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                hilo_en_q, hilo_en_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Only the EX and MEM stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall_en[5], stall_en[2:0]};

  assign do_bubble  = stall_en[3] & ~stall_en[4];
  assign do_advance = ~stall_en[3];
  assign do_hold    = stall_en[3] & stall_en[4];

  always_comb begin
    valid_d   = valid_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    hilo_en_d = hilo_en_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    if (reset || flush) begin
      valid_d   = 1'b0;
      wr_addr_d = '0;
      wr_en_d   = 1'b0;
      wr_data_d = '0;
      hilo_en_d = 1'b0;
      hi_d      = '0;
      lo_d      = '0;
      acc_d     = '0;
      cnt_d     = '0;
    end else if (do_bubble) begin
      valid_d   = 1'b0;
      wr_addr_d = '0;
      wr_en_d   = 1'b0;
      wr_data_d = '0;
      hilo_en_d = 1'b0;
      hi_d      = '0;
      lo_d      = '0;
      acc_d     = ex_acc_in;
      cnt_d     = ex_cnt_in;
    end else if (do_advance) begin
      valid_d   = ex_valid;
      wr_addr_d = ex_wr_addr;
      // Write enables are qualified so a dead slot can never commit.
      wr_en_d   = ex_wr_en & ex_valid;
      wr_data_d = ex_wr_data;
      hilo_en_d = ex_hilo_en & ex_valid;
      hi_d      = ex_hi;
      lo_d      = ex_lo;
      acc_d     = '0;
      cnt_d     = '0;
    end else if (do_hold) begin
      // Payload waits for MEM; the multi-cycle op keeps iterating in EX.
      acc_d     = ex_acc_in;
      cnt_d     = ex_cnt_in;
    end
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    wr_addr_q <= wr_addr_d;
    wr_en_q   <= wr_en_d;
    wr_data_q <= wr_data_d;
    hilo_en_q <= hilo_en_d;
    hi_q      <= hi_d;
    lo_q      <= lo_d;
    acc_q     <= acc_d;
    cnt_q     <= cnt_d;
  end

  assign mem_valid   = valid_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign mem_hilo_en = hilo_en_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign acc_out     = acc_q;
  assign cnt_out     = cnt_q;

`ifdef PIPE_EXMEM_PERF_EN
  logic [PERF_W-1:0] perf_bubble_q, perf_bubble_d;
  logic [PERF_W-1:0] perf_hold_q, perf_hold_d;

  always_comb begin
    perf_bubble_d = perf_bubble_q;
    perf_hold_d   = perf_hold_q;
    if (reset || perf_clr) begin
      perf_bubble_d = '0;
      perf_hold_d   = '0;
    end else if (!flush) begin
      // Saturating counters; flush cycles are not counted.
      if (do_bubble && (perf_bubble_q != {PERF_W{1'b1}})) begin
        perf_bubble_d = perf_bubble_q + PERF_W'(1);
      end
      if (do_hold && (perf_hold_q != {PERF_W{1'b1}})) begin
        perf_hold_d = perf_hold_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    perf_bubble_q <= perf_bubble_d;
    perf_hold_q   <= perf_hold_d;
  end

  assign perf_bubble_cnt = perf_bubble_q;
  assign perf_hold_cnt   = perf_hold_q;
`else
  logic [PERF_W-1:0] unused_perf_w;
  assign unused_perf_w = '0;
`endif

endmodule

// File: tb/tb_pipe_exmem.sv
module tb_pipe_exmem;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned PERF_W  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [5:0]          stall_en;
  logic                ex_valid;
  logic [RADDR_W-1:0]  ex_wr_addr;
  logic                ex_wr_en;
  logic [DATA_W-1:0]   ex_wr_data;
  logic                ex_hilo_en;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] ex_acc_in;
  logic [CNT_W-1:0]    ex_cnt_in;
  logic                mem_valid;
  logic [RADDR_W-1:0]  mem_wr_addr;
  logic                mem_wr_en;
  logic [DATA_W-1:0]   mem_wr_data;
  logic                mem_hilo_en;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [2*DATA_W-1:0] acc_out;
  logic [CNT_W-1:0]    cnt_out;
`ifdef PIPE_EXMEM_PERF_EN
  logic                perf_clr;
  logic [PERF_W-1:0]   perf_bubble_cnt;
  logic [PERF_W-1:0]   perf_hold_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipe_exmem #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .CNT_W   (CNT_W),
    .PERF_W  (PERF_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .stall_en    (stall_en),
    .ex_valid    (ex_valid),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_data  (ex_wr_data),
    .ex_hilo_en  (ex_hilo_en),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .ex_acc_in   (ex_acc_in),
    .ex_cnt_in   (ex_cnt_in),
    .mem_valid   (mem_valid),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_hilo_en (mem_hilo_en),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .acc_out     (acc_out),
    .cnt_out     (cnt_out)
`ifdef PIPE_EXMEM_PERF_EN
    ,
    .perf_clr        (perf_clr),
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_hold_cnt   (perf_hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1 ns after the edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input logic [63:0] exp_bubble,
                            input logic [63:0] exp_hold);
`ifdef PIPE_EXMEM_PERF_EN
    check({tag, "_bubble_cnt"}, 64'(perf_bubble_cnt), exp_bubble);
    check({tag, "_hold_cnt"}, 64'(perf_hold_cnt), exp_hold);
`else
    if (exp_bubble === 64'hx || exp_hold === 64'hx) $display("perf expectation %s unknown", tag);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(mem_valid), 64'd0);
    check({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'd0);
    check({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
    check({tag, "_wr_data"}, 64'(mem_wr_data), 64'd0);
    check({tag, "_hilo_en"}, 64'(mem_hilo_en), 64'd0);
    check({tag, "_hi"}, 64'(mem_hi), 64'd0);
    check({tag, "_lo"}, 64'(mem_lo), 64'd0);
    check({tag, "_acc"}, acc_out, 64'd0);
    check({tag, "_cnt"}, 64'(cnt_out), 64'd0);
    check_perf(tag, 64'd0, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    stall_en   = 6'b0;
    ex_valid   = 1'b0;
    ex_wr_addr = '0;
    ex_wr_en   = 1'b0;
    ex_wr_data = '0;
    ex_hilo_en = 1'b0;
    ex_hi      = '0;
    ex_lo      = '0;
    ex_acc_in  = '0;
    ex_cnt_in  = '0;
`ifdef PIPE_EXMEM_PERF_EN
    perf_clr   = 1'b0;
`endif
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // Plain advance with GPR and HI/LO writes.
    ex_valid   = 1'b1;
    ex_wr_en   = 1'b1;
    ex_wr_addr = 5'd7;
    ex_wr_data = 32'hDEADBEEF;
    ex_hilo_en = 1'b1;
    ex_hi      = 32'hAAAA0001;
    ex_lo      = 32'h5555_0002;
    ex_acc_in  = 64'h1234;
    ex_cnt_in  = 2'd2;
    step();
    check("adv_valid", 64'(mem_valid), 64'd1);
    check("adv_wr_addr", 64'(mem_wr_addr), 64'd7);
    check("adv_wr_data", 64'(mem_wr_data), 64'hDEADBEEF);
    check("adv_wr_en", 64'(mem_wr_en), 64'd1);
    check("adv_hilo_en", 64'(mem_hilo_en), 64'd1);
    check("adv_hi", 64'(mem_hi), 64'hAAAA0001);
    check("adv_lo", 64'(mem_lo), 64'h55550002);
    check("adv_acc", acc_out, 64'd0);
    check("adv_cnt", 64'(cnt_out), 64'd0);

    // Invalid slot: enables must be masked, data still transfers.
    ex_valid   = 1'b0;
    ex_wr_data = 32'h0BADF00D;
    step();
    check("inv_valid", 64'(mem_valid), 64'd0);
    check("inv_wr_en", 64'(mem_wr_en), 64'd0);
    check("inv_hilo_en", 64'(mem_hilo_en), 64'd0);
    check("inv_wr_data", 64'(mem_wr_data), 64'h0BADF00D);

    // Bubble carrying a multi-cycle op.
    ex_valid  = 1'b1;
    stall_en  = 6'b001000;
    ex_acc_in = 64'h1_0000_0002;
    ex_cnt_in = 2'b01;
    step();
    check("bub_valid", 64'(mem_valid), 64'd0);
    check("bub_wr_data", 64'(mem_wr_data), 64'd0);
    check("bub_wr_en", 64'(mem_wr_en), 64'd0);
    check("bub_hi", 64'(mem_hi), 64'd0);
    check("bub_acc", acc_out, 64'h1_0000_0002);
    check("bub_cnt", 64'(cnt_out), 64'd1);
    check_perf("bub", 64'd1, 64'd0);

    // Stall bits other than 3/4 are ignored: this is an advance.
    stall_en   = 6'b100111;
    ex_wr_addr = 5'd19;
    ex_wr_data = 32'h12345678;
    step();
    check("ign_wr_addr", 64'(mem_wr_addr), 64'd19);
    check("ign_wr_data", 64'(mem_wr_data), 64'h12345678);
    check("ign_acc", acc_out, 64'd0);
    check_perf("ign", 64'd1, 64'd0);

    // Hold for 3 cycles: payload frozen, acc follows EX (full 64 bits, no extension).
    stall_en   = 6'b011000;
    ex_wr_data = 32'hCAFEF00D;
    ex_acc_in  = 64'hFFFF_FFFF_0000_0001;
    ex_cnt_in  = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_wr_data", 64'(mem_wr_data), 64'h12345678);
      check("hold_valid", 64'(mem_valid), 64'd1);
    end
    check("hold_acc", acc_out, 64'hFFFF_FFFF_0000_0001);
    check("hold_cnt", 64'(cnt_out), 64'd3);
    check_perf("hold", 64'd1, 64'd3);

    // Bubble to load a nonzero acc, then flush over the stall.
    stall_en  = 6'b001000;
    ex_acc_in = 64'h5;
    ex_cnt_in = 2'd2;
    step();
    check("pre_flush_acc", acc_out, 64'h5);
    check_perf("pre_flush", 64'd2, 64'd3);
    flush = 1'b1;
    step();
    check("flush_acc", acc_out, 64'd0);
    check("flush_cnt", 64'(cnt_out), 64'd0);
    check("flush_valid", 64'(mem_valid), 64'd0);
    check("flush_wr_data", 64'(mem_wr_data), 64'd0);
    check_perf("flush", 64'd2, 64'd3);
    flush = 1'b0;

`ifdef PIPE_EXMEM_PERF_EN
    // Clear beats increment, then saturate the bubble counter.
    perf_clr = 1'b1;
    stall_en = 6'b011000;
    step();
    check_perf("clr", 64'd0, 64'd0);
    perf_clr = 1'b0;
`endif
    stall_en = 6'b001000;
    for (int i = 0; i < 20; i++) step();
`ifdef PIPE_EXMEM_PERF_EN
    check_perf("sat", 64'hF, 64'd0);
`endif

    // Reset in the middle of a hold discards everything.
    stall_en   = 6'b000000;
    ex_valid   = 1'b1;
    ex_wr_en   = 1'b1;
    ex_hilo_en = 1'b1;
    ex_wr_data = 32'hA5A5A5A5;
    step();
    check("pre_rst_wr_data", 64'(mem_wr_data), 64'hA5A5A5A5);
    stall_en  = 6'b011000;
    ex_acc_in = 64'h77;
    ex_cnt_in = 2'd1;
    step();
    check("pre_rst_acc", acc_out, 64'h77);
    reset = 1'b1;
    step();
    check_all_zero("rst_hold");
    reset = 1'b0;
    step();
    check("post_rst_wr_data", 64'(mem_wr_data), 64'd0);
    check("post_rst_valid", 64'(mem_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
